// File: rtl/riscv_run_monitor_pkg.sv
// riscv_run_pkg: shared state encoding, default parameters and width helper
// for the run monitor.
// Contents:
//   state_t  - IDLE, RESET, RUN, CHECK, DONE
//   *_DEF    - default parameter values
//   idx_w()  - index width for n channels (never below 1)
package riscv_run_pkg;

    typedef enum logic [2:0] {IDLE, RESET, RUN, CHECK, DONE} state_t;

    localparam int XLEN_DEF         = 64;
    localparam int NUM_PROBES_DEF   = 4;
    localparam int RESET_CYCLES_DEF = 2;
    localparam int HALT_STABLE_DEF  = 3;
    localparam int TIMEOUT_DEF      = 1024;
    localparam int CNT_W_DEF        = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_run_monitor_if.sv
// riscv_run_monitor_if: run-control and probe bus between a test harness and
// the run monitor.
// Signals:
//   start, pc, probe_val, expected, probe_mask      harness -> monitor
//   core_reset, busy, done, pass, timeout,
//   cycle_count, mismatch, fail_idx                 monitor -> harness
// Modports: master (harness side), slave (monitor side).
interface riscv_run_monitor_if import riscv_run_pkg::*; #(
    parameter int XLEN       = XLEN_DEF,
    parameter int NUM_PROBES = NUM_PROBES_DEF,
    parameter int CNT_W      = CNT_W_DEF
);
    localparam int IW = idx_w(NUM_PROBES);

    logic                       start;
    logic [XLEN-1:0]            pc;
    logic [NUM_PROBES*XLEN-1:0] probe_val;
    logic [NUM_PROBES*XLEN-1:0] expected;
    logic [NUM_PROBES-1:0]      probe_mask;
    logic                       core_reset;
    logic                       busy;
    logic                       done;
    logic                       pass;
    logic                       timeout;
    logic [CNT_W-1:0]           cycle_count;
    logic [NUM_PROBES-1:0]      mismatch;
    logic [IW-1:0]              fail_idx;

    modport master (
        output start, pc, probe_val, expected, probe_mask,
        input  core_reset, busy, done, pass, timeout, cycle_count, mismatch, fail_idx
    );

    modport slave (
        input  start, pc, probe_val, expected, probe_mask,
        output core_reset, busy, done, pass, timeout, cycle_count, mismatch, fail_idx
    );

endinterface

// File: rtl/riscv_run_monitor_probe_compare.sv
// probe_compare: masked per-channel equality compare with a lowest-index
// priority encoder over the failing channels.
// Ports:
//   probe_val_i  packed probe values, channel i at [i*XLEN +: XLEN]
//   expected_i   packed expected values, same packing
//   mask_i       1 = channel is compared
//   mismatch_o   per-channel compare failure
//   fail_idx_o   lowest failing channel, 0 if none
module probe_compare import riscv_run_pkg::*; #(
    parameter int XLEN       = XLEN_DEF,
    parameter int NUM_PROBES = NUM_PROBES_DEF,
    localparam int IW        = idx_w(NUM_PROBES)
) (
    input  logic [NUM_PROBES*XLEN-1:0] probe_val_i,
    input  logic [NUM_PROBES*XLEN-1:0] expected_i,
    input  logic [NUM_PROBES-1:0]      mask_i,
    output logic [NUM_PROBES-1:0]      mismatch_o,
    output logic [IW-1:0]              fail_idx_o
);

    // Walk from the top channel down so the lowest failing index is written last.
    always_comb begin
        mismatch_o = '0;
        fail_idx_o = '0;
        for (int i = NUM_PROBES - 1; i >= 0; i--) begin
            mismatch_o[i] = mask_i[i] && (probe_val_i[i*XLEN +: XLEN] != expected_i[i*XLEN +: XLEN]);
            if (mismatch_o[i]) fail_idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor: holds the core in reset, releases it, watches the PC for a
// self-loop halt or a timeout, then compares architectural probes once.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      riscv_run_monitor_if.slave (run request, PC, probes, results)
module riscv_run_monitor import riscv_run_pkg::*; #(
    parameter int XLEN         = XLEN_DEF,
    parameter int NUM_PROBES   = NUM_PROBES_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int HALT_STABLE  = HALT_STABLE_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset_n,
    riscv_run_monitor_if.slave bus
);

    localparam int IW = idx_w(NUM_PROBES);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(HALT_STABLE + 1);

    state_t                state_q, state_d;
    logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic                  pc_valid_q, pc_valid_d;
    logic [SW-1:0]         stable_q, stable_d;
    logic                  timeout_q, timeout_d;
    logic                  pass_q, pass_d;
    logic [NUM_PROBES-1:0] mismatch_q, mismatch_d, cmp_mismatch;
    logic [IW-1:0]         fail_idx_q, fail_idx_d, cmp_idx;

    probe_compare #(.XLEN(XLEN), .NUM_PROBES(NUM_PROBES)) u_cmp (
        .probe_val_i (bus.probe_val),
        .expected_i  (bus.expected),
        .mask_i      (bus.probe_mask),
        .mismatch_o  (cmp_mismatch),
        .fail_idx_o  (cmp_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rst_cnt_q  <= '0;
            cnt_q      <= '0;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            stable_q   <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= '0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            stable_q   <= stable_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
            mismatch_q <= mismatch_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        stable_d   = stable_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        mismatch_d = mismatch_q;
        fail_idx_d = fail_idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = RESET;
                    rst_cnt_d  = '0;
                    cnt_d      = '0;
                    pc_valid_d = 1'b0;
                    stable_d   = '0;
                    timeout_d  = 1'b0;
                    pass_d     = 1'b0;
                    mismatch_d = '0;
                    fail_idx_d = '0;
                end
            end
            RESET: begin
                rst_cnt_d = rst_cnt_q + RW'(1);
                if (rst_cnt_q == RW'(RESET_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
                cnt_d      = cnt_q + CNT_W'(1);
                pc_d       = bus.pc;
                pc_valid_d = 1'b1;
                stable_d   = (pc_valid_q && bus.pc == pc_q) ? stable_q + SW'(1) : '0;
                // Halt is tested first so a coincident timeout is not reported.
                if (stable_d == SW'(HALT_STABLE)) begin
                    state_d = CHECK;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    state_d   = CHECK;
                    timeout_d = 1'b1;
                end
            end
            CHECK: begin
                mismatch_d = cmp_mismatch;
                fail_idx_d = cmp_idx;
                pass_d     = !timeout_q && (cmp_mismatch == '0);
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Core runs only in RUN and CHECK, so probes are sampled from a live core.
    assign bus.core_reset  = !(state_q == RUN || state_q == CHECK);
    assign bus.busy        = state_q == RESET || state_q == RUN || state_q == CHECK;
    assign bus.done        = state_q == DONE;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cnt_q;
    assign bus.mismatch    = mismatch_q;
    assign bus.fail_idx    = fail_idx_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// tb_riscv_run_monitor: directed-vector bench for riscv_run_monitor.
module tb_riscv_run_monitor;
    import riscv_run_pkg::*;

    localparam int XLEN = 64;
    localparam int NP   = 4;
    localparam int RC   = 2;
    localparam int HS   = 3;
    localparam int TO   = 16;
    localparam int CW   = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    riscv_run_monitor_if #(.XLEN(XLEN), .NUM_PROBES(NP), .CNT_W(CW)) bus ();

    riscv_run_monitor #(
        .XLEN(XLEN), .NUM_PROBES(NP), .RESET_CYCLES(RC),
        .HALT_STABLE(HS), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pc_at(input int k, input int lim);
        return 64'(4 * ((k - 1) < lim ? (k - 1) : lim));
    endfunction

    // Pulse start, confirm results are cleared, then time the core reset window.
    task automatic kick();
        int n;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("clr_done", bus.done, 0);
        check("clr_busy", bus.busy, 1);
        check("clr_cc", bus.cycle_count, 0);
        check("clr_pass", bus.pass, 0);
        check("clr_mm", bus.mismatch, 0);
        n = 0;
        while (bus.core_reset && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_len", n, RC);
    endtask

    task automatic do_run(input int lim, input int start_at, input int exp_cc,
                          input logic exp_pass, input logic exp_to,
                          input logic [3:0] exp_mm, input logic [1:0] exp_idx);
        int k;
        kick();
        k = 1;
        while (!bus.done && k < 100) begin
            bus.pc = pc_at(k, lim);
            bus.start = (k == start_at);
            if (k == exp_cc + 1) check("chk_core", bus.core_reset, 0);
            @(posedge clk); #1;
            k++;
        end
        bus.start = 1'b0;
        check("done_lat", k, exp_cc + 2);
        check("cc", bus.cycle_count, exp_cc);
        check("pass", bus.pass, exp_pass);
        check("timeout", bus.timeout, exp_to);
        check("mismatch", bus.mismatch, exp_mm);
        check("fail_idx", bus.fail_idx, exp_idx);
        check("done_core", bus.core_reset, 1);
        check("done_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [4*64-1:0] exp_v;
    logic [4*64-1:0] bad_v;

    initial begin
        exp_v = {64'hdead_0003, 64'h6, 64'h2000, 64'h1000};
        bad_v = {64'hbad, 64'h5, 64'h2000, 64'h1000};
        bus.start = 1'b0;
        bus.pc = '0;
        bus.expected = exp_v;
        bus.probe_val = exp_v;
        bus.probe_mask = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core", bus.core_reset, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cc", bus.cycle_count, 0);
        check("rst_pass", bus.pass, 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", bus.busy, 0);
        check("idle_core", bus.core_reset, 1);

        do_run(3, 0, 7, 1'b1, 1'b0, 4'b0000, 2'd0);

        bus.probe_val = bad_v;
        bus.probe_mask = 4'b0111;
        do_run(3, 0, 7, 1'b0, 1'b0, 4'b0100, 2'd2);

        bus.probe_val = exp_v;
        bus.probe_mask = 4'b1111;
        do_run(1000, 0, 16, 1'b0, 1'b1, 4'b0000, 2'd0);
        do_run(12, 0, 16, 1'b1, 1'b0, 4'b0000, 2'd0);
        do_run(3, 3, 7, 1'b1, 1'b0, 4'b0000, 2'd0);

        kick();
        for (int k = 1; k <= 3; k++) begin
            bus.pc = pc_at(k, 1000);
            @(posedge clk); #1;
        end
        check("pre_abort_cc", bus.cycle_count, 3);
        check("pre_abort_core", bus.core_reset, 0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_core", bus.core_reset, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_cc", bus.cycle_count, 0);
        check("abort_done", bus.done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_run(3, 0, 7, 1'b1, 1'b0, 4'b0000, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
